if_fetch_queue: RTL

- Instruction-fetch front end that sits directly upstream of the memory controller and feeds the decode stage.
- Owns the fetch PC and issues one instruction request at a time to the memory controller.
- Captures each returned instruction with its PC in a small FIFO, and flushes and redirects on branch/jump resolution.
- Decouples memory-controller latency (1 cycle on cache hit, about 5 on miss) from the decode stage.

---
 rtl/if_fetch_queue_pkg.sv | 24 ++
 rtl/if_fetch_queue_if.sv | 25 ++
 rtl/if_fetch_queue_inst_fifo.sv | 63 ++++++
 rtl/if_fetch_queue.sv | 93 +++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Imported by the interface, the FIFO and the fetch controller.
package if_fetch_queue_pkg;

   typedef enum logic [1:0] {
      S_IDLE         = 2'b00,
      S_WAIT         = 2'b01,
      S_WAIT_DISCARD = 2'b10
   } fetch_state_e;

   localparam logic [31:0] PC_INCR   = 32'd4;
   localparam logic [31:0] ZERO_WORD = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fifo_entry_t;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_INCR;
   endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Memory-side and decode-side handshake bundle of the fetch queue.
// master = fetch queue view, slave = memory controller / decode view.
interface if_fetch_queue_if;
   logic        fetch_req_o;
   logic [31:0] fetch_pc_o;
   logic        mem_grant_i;
   logic        mem_pc_done_i;
   logic [31:0] mem_inst_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        id_ready_i;

   modport master (
      output fetch_req_o, fetch_pc_o, if_valid_o, if_pc_o, if_inst_o,
      input  mem_grant_i, mem_pc_done_i, mem_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );

   modport slave (
      input  fetch_req_o, fetch_pc_o, if_valid_o, if_pc_o, if_inst_o,
      output mem_grant_i, mem_pc_done_i, mem_inst_i, redirect_i, redirect_pc_i, id_ready_i
   );
endinterface

// File: rtl/if_fetch_queue_inst_fifo.sv
// Registered {pc, inst} FIFO; no write-to-head bypass.
// Flush and reset clear pointers and count; storage is left as is.
module inst_fifo
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic          flush_i,
   input  fifo_entry_t   data_i,
   output fifo_entry_t   head_o,
   output logic [CW-1:0] count_o
);

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush_i && push_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one memory request
// at a time and buffers returned instructions for decode.
//
// state          | meaning
// S_IDLE         | no request outstanding; request when a slot is free
// S_WAIT         | request accepted, instruction will be queued on done
// S_WAIT_DISCARD | request accepted before a redirect; its done is dropped
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy_in,
   if_fetch_queue_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          fetch_req;
   logic          push, pop, flush;
   logic          room, valid;
   logic [CW-1:0] count;
   fifo_entry_t   head;
   fifo_entry_t   push_data;

   assign room      = count < CW'(DEPTH);
   assign valid     = (count != '0) && !rst;
   assign push_data = '{pc: fetch_pc_q, inst: bus.mem_inst_i};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      fetch_req  = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      flush      = 1'b0;
      if (rdy_in && !rst) begin
         // Slot is reserved before issuing, so a push never finds the queue full.
         fetch_req = (state_q == S_IDLE) && room && !bus.redirect_i;
         if (bus.redirect_i) begin
            flush      = 1'b1;
            fetch_pc_d = bus.redirect_pc_i;
            if (state_q != S_IDLE)
               state_d = bus.mem_pc_done_i ? S_IDLE : S_WAIT_DISCARD;
         end else begin
            pop = valid && bus.id_ready_i;
            case (state_q)
               S_IDLE: if (fetch_req && bus.mem_grant_i) state_d = S_WAIT;
               S_WAIT: if (bus.mem_pc_done_i) begin
                  push       = 1'b1;
                  fetch_pc_d = next_pc(fetch_pc_q);
                  state_d    = S_IDLE;
               end
               S_WAIT_DISCARD: if (bus.mem_pc_done_i) state_d = S_IDLE;
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   inst_fifo #(.DEPTH(DEPTH)) u_inst_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  (push_data),
      .head_o  (head),
      .count_o (count)
   );

   assign bus.fetch_req_o = fetch_req;
   assign bus.fetch_pc_o  = fetch_pc_q;
   assign bus.if_valid_o  = valid;
   assign bus.if_pc_o     = valid ? head.pc   : ZERO_WORD;
   assign bus.if_inst_o   = valid ? head.inst : ZERO_WORD;

endmodule
